// File: rtl/acc_out_pkg.sv
// Shared types and sizing helpers for the accumulator output serializer.
// The saturation limits are consumed only when ACC_OUT_SATURATE_EN is defined.
package acc_out_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Narrow beats produced from one wide accumulator beat.
  function automatic int calc_beats(input int cores, input int units, input int out_words);
    return (cores * units) / out_words;
  endfunction

  // A single-beat configuration still needs a one-bit counter.
  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Largest positive value of a signed word of the given width, held in 64 bits.
  function automatic logic [63:0] sat_max(input int bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction

  // Most negative value of a signed word of the given width, sign-extended to 64 bits.
  function automatic logic [63:0] sat_min(input int bits);
    return ~sat_max(bits);
  endfunction

  localparam int DEF_CORES     = 32;
  localparam int DEF_UNITS     = 8;
  localparam int DEF_OUT_WORDS = 4;
  localparam int DEF_BEATS     = calc_beats(DEF_CORES, DEF_UNITS, DEF_OUT_WORDS);
  localparam int DEF_CNT_W     = calc_cnt_w(DEF_BEATS);

endpackage

// File: rtl/acc_word_convert.sv
// Converts one signed accumulator word to the output word width.
// Widening sign-extends; narrowing wraps, or clamps when ACC_OUT_SATURATE_EN is defined.
module acc_word_convert
  import acc_out_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_word,
  output logic [OUT_W-1:0] out_word
);

  generate
    if (OUT_W >= IN_W) begin : g_extend
      assign out_word = OUT_W'($signed(in_word));
    end else begin : g_narrow
`ifdef ACC_OUT_SATURATE_EN
      localparam logic [OUT_W-1:0] POS_LIMIT = OUT_W'(sat_max(OUT_W));
      localparam logic [OUT_W-1:0] NEG_LIMIT = OUT_W'(sat_min(OUT_W));

      logic [IN_W-OUT_W:0] top_bits;
      logic                fits;

      // The value fits when every bit from the output sign bit upward agrees.
      assign top_bits = in_word[IN_W-1:OUT_W-1];
      assign fits     = (&top_bits) | (~|top_bits);

      always_comb begin
        out_word = in_word[OUT_W-1:0];
        if (!fits) begin
          out_word = in_word[IN_W-1] ? NEG_LIMIT : POS_LIMIT;
        end
      end
`else
      logic unused_high_bits;

      assign unused_high_bits = ^in_word[IN_W-1:OUT_W];
      assign out_word         = in_word[OUT_W-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/axis_acc_out_serializer.sv
// Holds one wide accumulator beat and streams it out OUT_WORDS converted words at a time.
// Optional clamping of narrowed words is enabled by defining ACC_OUT_SATURATE_EN.
module axis_acc_out_serializer
  import acc_out_pkg::*;
#(
  parameter int CORES          = 32,
  parameter int UNITS          = 8,
  parameter int WORD_WIDTH_ACC = 25,
  parameter int OUT_WORD_BITS  = 16,
  parameter int OUT_WORDS      = 4,
  parameter int TUSER_WIDTH    = 8
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  input  logic [WORD_WIDTH_ACC*CORES*UNITS-1:0] s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  output logic [OUT_WORD_BITS*OUT_WORDS-1:0]    m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]                m_axis_tuser
);

  // Both streams use valid/ready: a transfer happens on a clock edge where both are
  // high, and a source holds valid and its payload steady until that edge.
  localparam int DATA_W  = WORD_WIDTH_ACC * CORES * UNITS;
  localparam int SLICE_W = WORD_WIDTH_ACC * OUT_WORDS;
  localparam int BEATS   = calc_beats(CORES, UNITS, OUT_WORDS);
  localparam int CNT_W   = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                   tlast_q, tlast_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

  logic                   s_ready;
  logic                   m_valid;
  logic                   is_last;
  logic [SLICE_W-1:0]     slice;

  assign is_last = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    tuser_d    = tuser_q;
    tlast_d    = tlast_q;
    beat_cnt_d = beat_cnt_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_axis_tvalid) begin
          data_d     = s_axis_tdata;
          tuser_d    = s_axis_tuser;
          tlast_d    = s_axis_tlast;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        m_valid = 1'b1;
        // The next wide beat is taken only as the final narrow beat leaves.
        s_ready = is_last & m_axis_tready;
        if (m_axis_tready) begin
          if (!is_last) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else if (s_axis_tvalid) begin
            data_d     = s_axis_tdata;
            tuser_d    = s_axis_tuser;
            tlast_d    = s_axis_tlast;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Word group for the current narrow beat, taken straight from the held register.
  always_comb begin
    slice = data_q[int'(beat_cnt_q) * SLICE_W +: SLICE_W];
  end

  genvar j;
  generate
    for (j = 0; j < OUT_WORDS; j++) begin : g_conv
      acc_word_convert #(
        .IN_W  (WORD_WIDTH_ACC),
        .OUT_W (OUT_WORD_BITS)
      ) u_conv (
        .in_word  (slice[j*WORD_WIDTH_ACC +: WORD_WIDTH_ACC]),
        .out_word (m_axis_tdata[j*OUT_WORD_BITS +: OUT_WORD_BITS])
      );
    end
  endgenerate

  assign s_axis_tready = s_ready & ~areset;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tlast  = m_valid & tlast_q & is_last;
  assign m_axis_tuser  = tuser_q;

endmodule
